bsel_mux: RTL and testbench

Operand-B select stage for the RV32I datapath: chooses between the register-file read value and the immediate as the ALU's second operand. A one-deep registered pipeline slot with a valid/ready handshake decouples decode from the ALU. A compile-time bypass makes the block purely combinational for the single-cycle build.

---
 rtl/bsel_mux.sv | 45 ++++
 tb/tb_bsel_mux.sv | 126 ++++++++++++
 2 files changed

// File: rtl/bsel_mux.sv
// bsel_mux: operand-B select (rF_ip vs imm) behind a one-deep valid/ready slot; BSEL_MUX_BYPASS_EN makes it purely combinational
module bsel_mux #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] rF_ip,
  input  logic [width-1:0] imm,
  input  logic             BSel_pin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] Bsel_op,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [width-1:0] sel;
  assign sel = BSel_pin ? imm : rF_ip;
`ifdef BSEL_MUX_BYPASS_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign Bsel_op   = sel;
  assign out_valid = in_valid;
  assign in_ready  = out_ready;
`else
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]       state;
  logic [width-1:0] data;
  logic             accept;
  assign in_ready  = (state == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);
  assign Bsel_op   = data;
  // slot register: load on accept, go empty on drain without a new operand, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
    end else begin
      if (accept) data <= sel;
      state <= (accept || (state == FULL && !out_ready)) ? FULL : EMPTY;
    end
  end
`endif
endmodule

// File: tb/tb_bsel_mux.sv
// tb_bsel_mux: directed and randomized checks of bsel_mux against a queue-based slot model
module tb_bsel_mux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rF_ip = 32'h0;
  logic [31:0] imm = 32'h0;
  logic        BSel_pin = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [31:0] Bsel_op;
  logic        out_valid;
  int checks = 0;
  int failures = 0;
  logic [31:0] q[$];
  logic [31:0] last_val = 32'h0;

  bsel_mux #(.width(32)) dut (
    .clk(clk), .rst_n(rst_n), .rF_ip(rF_ip), .imm(imm), .BSel_pin(BSel_pin),
    .in_valid(in_valid), .in_ready(in_ready), .Bsel_op(Bsel_op),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifndef BSEL_MUX_BYPASS_EN
  task automatic step(input logic v, input logic b, input logic r,
                      input logic [31:0] rf, input logic [31:0] im, input string tag);
    @(negedge clk);
    in_valid = v; BSel_pin = b; out_ready = r; rF_ip = rf; imm = im;
    #1;
    chk({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, (q.size() == 0) || r});
    @(posedge clk);
    if (r && q.size() != 0) void'(q.pop_front());
    if (v && q.size() == 0) begin
      q.push_back(b ? im : rf);
      last_val = b ? im : rf;
    end
    #1;
    chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk({tag, ".Bsel_op"}, Bsel_op, last_val);
  endtask
`endif

  initial begin
`ifdef BSEL_MUX_BYPASS_EN
    rF_ip = 32'h00005555; imm = 32'h00001111; in_valid = 1'b1; out_ready = 1'b0;
    BSel_pin = 1'b0;
    #5;
    chk("byp.sel_rf", Bsel_op, 32'h00005555);
    chk("byp.out_valid", {31'b0, out_valid}, 32'h1);
    chk("byp.in_ready0", {31'b0, in_ready}, 32'h0);
    BSel_pin = 1'b1;
    #1;
    chk("byp.sel_imm", Bsel_op, 32'h00001111);
    #4;
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("byp.in_ready1", {31'b0, in_ready}, 32'h1);
    chk("byp.out_valid0", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b2;
      logic s, v, r;
      a = $urandom; b2 = $urandom; s = 1'($urandom); v = 1'($urandom); r = 1'($urandom);
      rF_ip = a; imm = b2; BSel_pin = s; in_valid = v; out_ready = r;
      #1;
      chk("byp.rand_op", Bsel_op, s ? b2 : a);
      chk("byp.rand_ov", {31'b0, out_valid}, {31'b0, v});
      chk("byp.rand_ir", {31'b0, in_ready}, {31'b0, r});
      #4;
    end
`else
    rF_ip = 32'hDEADBEEF; imm = 32'hCAFEF00D; BSel_pin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #2;
    chk("reset.Bsel_op", Bsel_op, 32'h0);
    chk("reset.out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 32'h00005555, 32'h00001111, "sel_rf");
    chk("sel_rf.const", Bsel_op, 32'h00005555);
    step(1'b1, 1'b1, 1'b1, 32'h00005555, 32'h00001111, "sel_imm");
    chk("sel_imm.const", Bsel_op, 32'h00001111);
    step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, "drain");
    chk("drain.valid", {31'b0, out_valid}, 32'h0);
    chk("drain.hold", Bsel_op, 32'h00001111);
    step(1'b1, 1'b0, 1'b1, 32'h00005555, 32'h00001111, "bp_load");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h00005555, 32'hFFFFFFFF, "bp_stall");
      chk("bp_stall.in_ready", {31'b0, in_ready}, 32'h0);
      chk("bp_stall.const", Bsel_op, 32'h00005555);
    end
    step(1'b1, 1'b1, 1'b1, 32'h00005555, 32'hFFFFFFFF, "bp_release");
    chk("bp_release.const", Bsel_op, 32'hFFFFFFFF);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'(i % 2), 1'b1, 32'h00005555, 32'h00001111, "stream");
      chk("stream.const", Bsel_op, (i % 2) ? 32'h00001111 : 32'h00005555);
      chk("stream.nobubble", {31'b0, out_valid}, 32'h1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete(); last_val = 32'h0;
    chk("midreset.Bsel_op", Bsel_op, 32'h0);
    chk("midreset.out_valid", {31'b0, out_valid}, 32'h0);
    chk("midreset.in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0),
           $urandom, $urandom, "rand");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
